// File: rtl/cpu_pkg.sv
// Shared widths and fetch FSM state encoding for the instruction fetch slice.
package cpu_pkg;

    localparam int PC_W   = 28;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    // Word address presented to instruction memory for a given PC.
    function automatic logic [ADDR_W-1:0] pc_to_addr(input logic [PC_W-1:0] pc);
        return pc[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_timeout.sv
// Cycle counter bounding how long a fetch may wait for imem_ack.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Count waiting cycles; cleared whenever no request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches the instruction at pc_in over a req/ack memory port and hands it
// to decode through a valid/ready instruction register.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [PC_W-1:0]   pc_in,
    output logic              incpc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] ir_out,
    output logic [PC_W-1:0]   ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              fetch_err
);

    fetch_state_e      r_state;
    logic [PC_W-1:0]   r_pc_q;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_ir;
    logic [PC_W-1:0]   r_ir_pc;
    logic              r_req;
    logic              r_valid;
    logic              r_incpc;
    logic              r_fetch_err;
    logic              r_discard;
    logic              w_cnt_clear;
    logic              w_cnt_enable;
    logic              w_expired;

    assign w_cnt_clear  = (r_state != ST_WAIT);
    assign w_cnt_enable = (r_state == ST_WAIT) && !imem_ack;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_enable),
        .expired (w_expired)
    );

    // Fetch sequencing; every output is a register written only here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc_q      <= '0;
            r_addr      <= '0;
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_req       <= 1'b0;
            r_valid     <= 1'b0;
            r_incpc     <= 1'b0;
            r_fetch_err <= 1'b0;
            r_discard   <= 1'b0;
        end else begin
            r_incpc     <= 1'b0;
            r_fetch_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (en && !flush) begin
                        r_pc_q    <= pc_in;
                        r_addr    <= pc_to_addr(pc_in);
                        r_req     <= 1'b1;
                        r_discard <= 1'b0;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A flush coinciding with ack discards the word as well.
                    if (imem_ack) begin
                        r_req     <= 1'b0;
                        r_discard <= 1'b0;
                        if (r_discard || flush) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_ir    <= imem_rdata;
                            r_ir_pc <= r_pc_q;
                            r_valid <= 1'b1;
                            r_incpc <= 1'b1;
                            r_state <= ST_HOLD;
                        end
                    end else if (w_expired) begin
                        r_req       <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_discard   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (flush) begin
                        r_discard <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (flush || ir_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_req     <= 1'b0;
                    r_valid   <= 1'b0;
                    r_discard <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign incpc     = r_incpc;
    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign ir_out    = r_ir;
    assign ir_pc     = r_ir_pc;
    assign ir_valid  = r_valid;
    assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized bench for instruction_fetch_unit; the bench acts as
// program counter, instruction memory and decode, and predicts each handshake.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, en, flush, incpc, imem_req, imem_ack, ir_valid, ir_ready, fetch_err;
    logic [27:0] pc_in, ir_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata, ir_out;

    int   checks = 0;
    int   errors = 0;
    int   incpc_cnt = 0;
    int   err_cnt = 0;
    logic inc_pending = 1'b0;
    logic [31:0] d1, d2;
    int   inc0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .pc_in      (pc_in),
        .incpc      (incpc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir_out     (ir_out),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .fetch_err  (fetch_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the PC model advances one cycle after an incpc pulse, wrapping 255->0.
    task automatic tick();
        logic [7:0] nxt;
        @(posedge clk);
        #1;
        if (inc_pending) begin
            nxt   = pc_in[7:0] + 8'd1;
            pc_in = {20'd0, nxt};
        end
        inc_pending = incpc;
        if (incpc) incpc_cnt++;
        if (fetch_err) err_cnt++;
    endtask

    task automatic do_fetch(input int lat, input logic [31:0] data, input int rdy, input bit hflush);
        logic [27:0] exp_pc;
        int          i0;
        exp_pc = pc_in;
        i0     = incpc_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("req_issue", 64'({imem_req, imem_addr, ir_valid}), 64'({1'b1, exp_pc[7:0], 1'b0}));
        for (int i = 0; i < lat; i++) begin
            imem_rdata = $urandom();
            tick();
            chk("req_held", 64'({imem_req, imem_addr}), 64'({1'b1, exp_pc[7:0]}));
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        ir_ready   = (rdy == 0);
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom();
        chk("hold_entry", 64'({ir_valid, imem_req, incpc}), 64'(3'b101));
        chk("ir_out", 64'(ir_out), 64'(data));
        chk("ir_pc", 64'(ir_pc), 64'(exp_pc));
        for (int i = 0; i < rdy; i++) begin
            tick();
            chk("hold_stall", 64'({ir_valid, imem_req, incpc, ir_out}), 64'({3'b100, data}));
        end
        if (hflush) begin
            flush    = 1'b1;
            ir_ready = 1'($urandom_range(0, 1));
        end else begin
            ir_ready = 1'b1;
        end
        tick();
        flush    = 1'b0;
        ir_ready = 1'b0;
        chk("hold_exit", 64'({ir_valid, imem_req, incpc}), 64'd0);
        chk("incpc_once", 64'(incpc_cnt - i0), 64'd1);
        imem_ack   = 1'b1;
        imem_rdata = $urandom();
        tick();
        imem_ack = 1'b0;
        chk("idle_ignore", 64'({ir_valid, imem_req, incpc}), 64'd0);
    endtask

    task automatic do_timeout(input bit with_flush);
        logic [27:0] exp_pc;
        int          i0, e0;
        exp_pc = pc_in;
        i0     = incpc_cnt;
        e0     = err_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("to_issue", 64'({imem_req, imem_addr}), 64'({1'b1, exp_pc[7:0]}));
        for (int i = 0; i < 14; i++) begin
            flush = with_flush && (i == 3);
            tick();
            chk("to_wait", 64'({imem_req, fetch_err}), 64'(2'b10));
        end
        flush = 1'b0;
        tick();
        chk("to_abort", 64'({imem_req, fetch_err, incpc, ir_valid}), 64'(4'b0100));
        tick();
        chk("to_pulse", 64'(fetch_err), 64'd0);
        chk("to_err_once", 64'(err_cnt - e0), 64'd1);
        chk("to_no_incpc", 64'(incpc_cnt - i0), 64'd0);
        do_fetch(int'($urandom_range(0, 14)), $urandom(), int'($urandom_range(0, 2)), 1'b0);
    endtask

    task automatic do_flush_wait(input int pre, input int post);
        logic [27:0] exp_pc;
        int          i0;
        exp_pc = pc_in;
        i0     = incpc_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("fl_issue", 64'({imem_req, imem_addr}), 64'({1'b1, exp_pc[7:0]}));
        repeat (pre) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_req_kept", 64'({imem_req, imem_addr}), 64'({1'b1, exp_pc[7:0]}));
        repeat (post) tick();
        imem_ack   = 1'b1;
        imem_rdata = $urandom();
        tick();
        imem_ack = 1'b0;
        chk("fl_drop", 64'({ir_valid, imem_req, incpc}), 64'd0);
        tick();
        chk("fl_idle", 64'({ir_valid, imem_req, incpc}), 64'd0);
        chk("fl_no_incpc", 64'(incpc_cnt - i0), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; pc_in = 28'd0;
        imem_ack = 1'b0; imem_rdata = 32'd0; ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({incpc, imem_req, imem_addr, ir_valid, fetch_err}), 64'd0);
        chk("rst_ir", 64'(ir_out), 64'd0);
        chk("rst_irpc", 64'(ir_pc), 64'd0);
        rst_n = 1'b1;
        tick();

        pc_in = 28'h05;
        do_fetch(3, 32'hDEADBEEF, 0, 1'b0);
        do_fetch(2, $urandom(), 5, 1'b0);

        // Asynchronous reset in the middle of a WAIT.
        pc_in = 28'h33;
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("mid_req", 64'(imem_req), 64'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_ctrl", 64'({incpc, imem_req, imem_addr, ir_valid, fetch_err}), 64'd0);
        chk("async_ir", 64'({ir_out, ir_pc}), 64'd0);
        inc_pending = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 64'(imem_req), 64'd0);

        do_flush_wait(1, 1);
        do_fetch(0, $urandom(), 0, 1'b0);
        do_timeout(1'b0);
        do_timeout(1'b1);
        do_fetch(1, $urandom(), 1, 1'b1);

        pc_in = 28'hFF;
        do_fetch(2, $urandom(), 0, 1'b0);
        do_fetch(0, 32'h1234_5678, 1, 1'b0);

        // Back-to-back fetch at best throughput.
        pc_in = 28'h10; en = 1'b1; ir_ready = 1'b1; imem_ack = 1'b1;
        d1 = $urandom(); d2 = $urandom(); imem_rdata = d1; inc0 = incpc_cnt;
        tick();
        chk("b2b_req0", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h10}));
        tick();
        chk("b2b_hold0", 64'({ir_valid, incpc, ir_out}), 64'({2'b11, d1}));
        imem_rdata = d2;
        tick();
        chk("b2b_idle", 64'({ir_valid, imem_req}), 64'd0);
        tick();
        chk("b2b_req1", 64'({imem_req, imem_addr}), 64'({1'b1, 8'h11}));
        tick();
        chk("b2b_hold1", 64'({ir_valid, incpc, ir_out}), 64'({2'b11, d2}));
        chk("b2b_irpc1", 64'(ir_pc), 64'h11);
        en = 1'b0;
        tick();
        chk("b2b_accept", 64'(ir_valid), 64'd0);
        imem_ack = 1'b0; ir_ready = 1'b0;
        tick();
        chk("b2b_stop", 64'(imem_req), 64'd0);
        chk("b2b_incpc", 64'(incpc_cnt - inc0), 64'd2);

        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            case (kind)
                0: do_timeout(1'($urandom_range(0, 1)));
                1: do_flush_wait(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
                default: begin
                    if (kind == 2) pc_in = 28'($urandom_range(0, 255));
                    do_fetch(int'($urandom_range(0, 14)), $urandom(),
                             int'($urandom_range(0, 4)), ($urandom_range(0, 4) == 0));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
